// File: rtl/cpu_pkg.sv
// Shared CPU types for the write-back path and the register-file write side.
package cpu_pkg;

    localparam int REG_ADDR_W = 4;
    localparam int DATA_W     = 16;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
    } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of write-back requests used to queue load results.
// With WB_HAZARD_CHECK_EN defined it also exports its entries and per-slot valid bits.
module wb_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    push,
    input  wb_req_t push_data,
    input  logic    pop,
    output wb_req_t head,
    output logic    full,
    output logic    empty
`ifdef WB_HAZARD_CHECK_EN
    ,
    output wb_req_t [DEPTH-1:0] entries,
    output logic    [DEPTH-1:0] entry_valid
`endif
);

    localparam int AW = $clog2(DEPTH);

    wb_req_t [DEPTH-1:0] mem_q, mem_d;
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [AW:0]         count_q, count_d;
    logic                do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign head    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

`ifdef WB_HAZARD_CHECK_EN
    logic [AW-1:0] offset;

    // A slot is live when its distance from the read pointer is below the fill count.
    always_comb begin
        offset      = '0;
        entry_valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset         = AW'(i) - rd_ptr_q;
            entry_valid[i] = ({1'b0, offset} < count_q);
        end
    end

    assign entries = mem_q;
`endif

endmodule

// File: rtl/reg_writeback_arbiter.sv
// Write-back arbiter: ALU results win the register-file port, loads queue and drain when the ALU is idle.
// Optional WB_HAZARD_CHECK_EN adds rs/rt in-flight write detection for the decode stage.
module reg_writeback_arbiter
    import cpu_pkg::*;
#(
    parameter int LD_DEPTH     = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  CLK,
    input  logic                  RST_n,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [REG_ADDR_W-1:0] alu_reg,
    input  logic [DATA_W-1:0]     alu_data,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [REG_ADDR_W-1:0] ld_reg,
    input  logic [DATA_W-1:0]     ld_data,
    output logic                  RegWre,
    output logic [REG_ADDR_W-1:0] WriteReg,
    output logic [DATA_W-1:0]     WriteData
`ifdef WB_HAZARD_CHECK_EN
    ,
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic [REG_ADDR_W-1:0] rt,
    output logic                  pend_rs,
    output logic                  pend_rt
`endif
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);

    wb_req_t               head;
    logic                  full, empty;
    logic                  starve, alu_accept, ld_push, pop;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  regwre_q, regwre_d;
    logic [REG_ADDR_W-1:0] write_reg_q, write_reg_d;
    logic [DATA_W-1:0]     write_data_q, write_data_d;

`ifdef WB_HAZARD_CHECK_EN
    wb_req_t [LD_DEPTH-1:0] entries;
    logic    [LD_DEPTH-1:0] entry_valid;
`endif

    wb_fifo #(
        .DEPTH (LD_DEPTH)
    ) u_ld_fifo (
        .clk        (CLK),
        .rst_n      (RST_n),
        .push       (ld_push),
        .push_data  ('{addr: ld_reg, data: ld_data}),
        .pop        (pop),
        .head       (head),
        .full       (full),
        .empty      (empty)
`ifdef WB_HAZARD_CHECK_EN
        ,
        .entries    (entries),
        .entry_valid(entry_valid)
`endif
    );

    // Handshakes are held low while reset is asserted.
    always_comb begin
        starve     = (cnt_q == CW'(STARVE_LIMIT)) && !empty;
        alu_ready  = RST_n && !starve;
        ld_ready   = RST_n && !full;
        alu_accept = alu_valid && alu_ready;
        ld_push    = ld_valid && ld_ready;
        pop        = !alu_accept && !empty;
    end

    always_comb begin
        cnt_d        = cnt_q;
        regwre_d     = 1'b0;
        write_reg_d  = write_reg_q;
        write_data_d = write_data_q;

        if (empty || pop) begin
            cnt_d = '0;
        end else if (cnt_q != CW'(STARVE_LIMIT)) begin
            cnt_d = cnt_q + 1'b1;
        end

        // Register 0 is hard-wired: its results are consumed but never written.
        if (alu_accept) begin
            regwre_d     = (alu_reg != '0);
            write_reg_d  = alu_reg;
            write_data_d = alu_data;
        end else if (pop) begin
            regwre_d     = (head.addr != '0);
            write_reg_d  = head.addr;
            write_data_d = head.data;
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            cnt_q        <= '0;
            regwre_q     <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
        end else begin
            cnt_q        <= cnt_d;
            regwre_q     <= regwre_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
        end
    end

    assign RegWre    = regwre_q;
    assign WriteReg  = write_reg_q;
    assign WriteData = write_data_q;

`ifdef WB_HAZARD_CHECK_EN
    always_comb begin
        pend_rs = regwre_q && (write_reg_q == rs);
        pend_rt = regwre_q && (write_reg_q == rt);
        for (int i = 0; i < LD_DEPTH; i++) begin
            if (entry_valid[i] && (entries[i].addr == rs)) pend_rs = 1'b1;
            if (entry_valid[i] && (entries[i].addr == rt)) pend_rt = 1'b1;
        end
        pend_rs = pend_rs && (rs != '0) && RST_n;
        pend_rt = pend_rt && (rt != '0) && RST_n;
    end
`endif

endmodule
